// File: rtl/jt1943_obj_pkg.sv
// Shared definitions for the 1943 object line buffer: pixel key values,
// controller state encoding and read-modify-write phase indices.
package jt1943_obj_pkg;

  // Low nibble that marks a see-through pixel coming from the palette PROM
  localparam logic [3:0] TRANSP = 4'hF;
  // Value used to erase the buffer and to drive the output when idle
  localparam logic [7:0] BLANK  = 8'hFF;

  // Controller states: CLEAR sweeps both banks, RUN is normal operation
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } obj_state_t;

  // Phases of one cen6 period: c0 is the cen6 cycle itself (capture and
  // read), c1 returns RAM data, c2 performs the write-back.
  localparam int PH_C0 = 0;
  localparam int PH_C1 = 1;
  localparam int PH_C2 = 2;

  // True when the pixel nibble equals the transparent key
  function automatic logic nib_is_key(input logic [3:0] nib, input logic [3:0] key);
    return (nib == key);
  endfunction

endpackage

// File: rtl/jt1943_objlinebuf_ram.sv
// Single-clock line RAM: one synchronous read port and one write port.
// Contents are not reset; the owner clears them with an explicit sweep.
module jt1943_objlinebuf_ram
  import jt1943_obj_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DW-1:0] rdata_r;

  // Write port: store wdata when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered read, data valid the cycle after the address
  always_ff @(posedge clk) begin
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/jt1943_objlinebuf.sv
// Double-buffered sprite line buffer. One bank is filled by the object draw
// stage (first opaque pixel at a location wins) while the other is played
// back to the colour mixer and erased behind the read pointer. Banks swap
// at each line start (falling edge of LHBL seen on cen6).
module jt1943_objlinebuf
  import jt1943_obj_pkg::*;
#(
  parameter int         AW     = 8,
  parameter int         DW     = 8,
  parameter logic [3:0] TRANSP = jt1943_obj_pkg::TRANSP,
  parameter logic [7:0] BLANK  = jt1943_obj_pkg::BLANK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen6,
  input  logic          LHBL,
  input  logic [8:0]    H,
  input  logic [8:0]    posx,
  input  logic [DW-1:0] new_pxl,
  output logic [DW-1:0] obj_pxl,
  output logic          busy
);

  // Controller
  obj_state_t    state_r;
  logic [AW-1:0] cnt_r;
  logic          busy_r;

  // Bank select
  logic          line_r;
  logic          lhbl_last_r;

  // Phase tracker: ph_r[PH_C1] is high one clk after cen6, ph_r[PH_C2] two
  logic [PH_C2:PH_C1] ph_r;

  // Draw pipeline (captured on c0, held for the whole cen6 period)
  logic          dr_v_r;
  logic          dr_bank_r;
  logic [AW-1:0] dr_addr_r;
  logic [DW-1:0] dr_data_r;
  logic          dr_free_r;

  // Display pipeline
  logic          dp_v_r;
  logic          dp_bank_r;
  logic [AW-1:0] dp_addr_r;
  logic [DW-1:0] hold_r;
  logic [DW-1:0] obj_pxl_r;

  // RAM ports, one entry per bank
  logic [AW-1:0] raddr_s [2];
  logic [DW-1:0] rdata_s [2];
  logic [1:0]    we_s;
  logic [AW-1:0] waddr_s [2];
  logic [DW-1:0] wdata_s [2];

  // Only the low AW bits of H address the buffer; the top bit is ignored
  logic h_msb_unused_s;
  assign h_msb_unused_s = H[8];

  // Clear sweep after reset, then stay in RUN until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + AW'(1);
          if (cnt_r == {AW{1'b1}}) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= '0;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Swap banks on the cen6 where LHBL is first seen low
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r      <= 1'b0;
      lhbl_last_r <= 1'b0;
    end else if (cen6) begin
      lhbl_last_r <= LHBL;
      line_r      <= line_r ^ (lhbl_last_r & ~LHBL);
    end else begin
      lhbl_last_r <= lhbl_last_r;
      line_r      <= line_r;
    end
  end

  // c0: capture draw and display requests together with their bank, so a
  // swap on this same cen6 does not redirect work already in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_r      <= '0;
      dr_v_r    <= 1'b0;
      dr_bank_r <= 1'b0;
      dr_addr_r <= '0;
      dr_data_r <= '0;
      dp_v_r    <= 1'b0;
      dp_bank_r <= 1'b0;
      dp_addr_r <= '0;
    end else begin
      ph_r <= {ph_r[PH_C1], cen6};
      if (cen6) begin
        dr_v_r    <= (state_r == ST_RUN) && !posx[8] &&
                     !nib_is_key(new_pxl[3:0], TRANSP);
        dr_bank_r <= line_r;
        dr_addr_r <= posx[AW-1:0];
        dr_data_r <= new_pxl;
        dp_v_r    <= (state_r == ST_RUN) && LHBL;
        dp_bank_r <= ~line_r;
        dp_addr_r <= H[AW-1:0];
      end
    end
  end

  // c1: decide whether the draw location is still free and grab the
  // playback value (BLANK when no playback read was issued)
  always_ff @(posedge clk) begin
    if (rst) begin
      dr_free_r <= 1'b0;
      hold_r    <= BLANK;
    end else if (ph_r[PH_C1]) begin
      dr_free_r <= nib_is_key(rdata_s[dr_bank_r][3:0], TRANSP);
      hold_r    <= dp_v_r ? rdata_s[dp_bank_r] : BLANK;
    end else begin
      dr_free_r <= dr_free_r;
      hold_r    <= hold_r;
    end
  end

  // Present the held playback value once per pixel; BLANK while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      obj_pxl_r <= BLANK;
    end else if (cen6) begin
      obj_pxl_r <= (state_r == ST_RUN) ? hold_r : BLANK;
    end
  end

  // Per-bank port steering: the draw bank reads posx, the display bank
  // reads H; writes come from the sweep, a winning draw or the erase
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      raddr_s[b] = ((b != 0) == line_r) ? posx[AW-1:0] : H[AW-1:0];
      we_s[b]    = 1'b0;
      waddr_s[b] = '0;
      wdata_s[b] = BLANK;
      if (state_r == ST_CLEAR) begin
        we_s[b]    = 1'b1;
        waddr_s[b] = cnt_r;
        wdata_s[b] = BLANK;
      end else if (ph_r[PH_C2] && dr_v_r && dr_free_r && (dr_bank_r == (b != 0))) begin
        we_s[b]    = 1'b1;
        waddr_s[b] = dr_addr_r;
        wdata_s[b] = dr_data_r;
      end else if (ph_r[PH_C2] && dp_v_r && (dp_bank_r == (b != 0))) begin
        we_s[b]    = 1'b1;
        waddr_s[b] = dp_addr_r;
        wdata_s[b] = BLANK;
      end else begin
        we_s[b]    = 1'b0;
        waddr_s[b] = '0;
        wdata_s[b] = BLANK;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jt1943_objlinebuf_ram #(
      .AW (AW),
      .DW (DW)
    ) u_ram (
      .clk   (clk),
      .raddr (raddr_s[g]),
      .rdata (rdata_s[g]),
      .we    (we_s[g]),
      .waddr (waddr_s[g]),
      .wdata (wdata_s[g])
    );
  end

  assign obj_pxl = obj_pxl_r;
  assign busy    = busy_r;

endmodule

// File: doc/jt1943_objlinebuf.md
Name: jt1943_objlinebuf

Overview:
- Double-buffered sprite line buffer sitting directly downstream of the object draw stage.
- Consumes the per-pixel stream (posx, new_pxl) produced at cen6 while the next line is being drawn.
- Resolves sprite-over-sprite priority: the first opaque pixel written to a location wins.
- Plays the previous line back to the colour mixer indexed by the horizontal counter, erasing each location after it is read.

Parameters:
- AW, 8, line buffer address width (256 pixels per line).
- DW, 8, pixel width (palette PROM output).
- TRANSP, 4'hF, value of pixel[3:0] that marks a transparent pixel.
- BLANK, 8'hFF, erase/idle value written to RAM and driven on obj_pxl.

Ports:
- clk  in  1  24 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- cen6  in  1  6 MHz pixel clock enable, one clk in four.
- LHBL  in  1  horizontal blank, active low; its falling edge marks line start.
- H  in  9  horizontal pixel counter; H[7:0] is the playback address.
- posx  in  9  draw x position; posx[8]=1 means skip the pixel.
- new_pxl  in  8  pixel from the draw stage.
- obj_pxl  out  8  sprite pixel for the current screen position.
- busy  out  1  high while the post-reset clear sweep runs.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on rst.
- Bank select:
  - 1-bit `line` register. Draw bank = line, display bank = ~line.
  - On a cen6 cycle where LHBL is sampled low and was high at the previous cen6, toggle line.
- Reset values: line=0, obj_pxl=BLANK, busy=1, clear counter=0, all pipeline valids=0.
- FSM, two states:
  - CLEAR: each clk writes BLANK to address cnt in both banks, then cnt++. After cnt=255 is written, move to RUN and set busy=0. The sweep takes 256 clk.
  - In CLEAR, draw inputs are ignored and obj_pxl=BLANK.
  - RUN: normal operation.
  - Asserting rst in any state, including mid-sweep, returns to CLEAR with cnt=0.
- Draw path (read-modify-write on the draw bank, 3 clk, all within one cen6 period):
  - c0 (cen6): if posx[8]=0 and new_pxl[3:0]!=TRANSP, capture addr=posx[7:0], data=new_pxl, bank=line, and valid=1. Issue a read of that address.
  - c1: RAM read data is returned.
  - c2: if the stored value has [3:0]==TRANSP, write data. Otherwise drop it (an earlier sprite has priority).
  - The captured bank travels with the pipeline, so a swap during c1/c2 completes into the old bank.
  - No forwarding is needed: consecutive pixels are 4 clk apart.
- Display path (display bank):
  - c0 (cen6), LHBL high: read address H[7:0].
  - c1: latch the read value into a holding register.
  - c2: write BLANK to the same address (erase for reuse two lines later).
  - obj_pxl takes the holding register at the next cen6, giving one cen6 of latency from H.
  - With LHBL low: no read, no erase, and obj_pxl=BLANK at the next cen6.
- Wrap-around: addresses are 8-bit. H[8] and posx[8] are never used as address bits.
- Simultaneous draw and display: the two accesses hit different banks and never conflict. The same bank is never both draw and display.

Decomposition:
- Shared package jt1943_obj_pkg holds:
  - TRANSP and BLANK constants.
  - FSM state encoding (CLEAR, RUN).
  - Pipeline phase indices c0..c2.
- One natural sub-module: jt1943_objlinebuf_ram. It is a 256x8 single-clock RAM with one synchronous-read port and one write port, instantiated twice.
- Bank muxing and both pipelines stay in the top module.

Test Plan:
- Reset release → busy=1 for exactly 256 clk. Every address in both banks then reads 8'hFF, and obj_pxl=8'hFF throughout.
- Line N: draw new_pxl=8'h23 at posx=9'd10. After the LHBL falling edge, with H=10 → obj_pxl=8'h23 one cen6 later. Line N+2 at H=10 → 8'hFF (erased).
- Priority: in the same line write 8'h41 then 8'h57 at posx=40 → playback gives 8'h41. Writing 8'h3F (transparent) then 8'h52 at posx=41 → 8'h52.
- Skip: posx=9'h100 with new_pxl=8'h12 → no write; all 256 playback values are 8'hFF.
- Swap in flight: assert the LHBL falling edge on the same cen6 as capturing posx=5, new_pxl=8'h66 → the pixel lands in the old draw bank and appears at H=5 on the following line.
- Reset mid-sweep: pulse rst at cnt=100 → busy stays high for a fresh 256 clk. Writes presented during the sweep are ignored, and playback reads 8'hFF.
